// File: rtl/fetch_queue_if.sv
// Handshake bundle between the fetch front end, instruction memory and the core.
// Every channel is valid/ready: a transfer happens in a cycle where both are high. An
// asserted request keeps its address stable until accepted, except that it may drop in a
// redirect cycle. mem_resp_valid and redirect are one-cycle pulses with no ready.
interface fetch_queue_if;
  logic        mem_req_valid;
  logic [31:0] mem_req_addr;
  logic        mem_req_ready;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_data;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic        out_ready;

  modport master (
    output mem_req_valid, mem_req_addr, out_valid, out_pc, out_instr,
    input  mem_req_ready, mem_resp_valid, mem_resp_data, redirect, redirect_pc, out_ready
  );

  modport slave (
    input  mem_req_valid, mem_req_addr, out_valid, out_pc, out_instr,
    output mem_req_ready, mem_resp_valid, mem_resp_data, redirect, redirect_pc, out_ready
  );
endinterface

// File: rtl/fetch_queue.sv
// Instruction fetch front end: credit-limited in-order fetch into a DEPTH-entry
// {pc, instr} queue, with redirect flushing the queue and dropping in-flight responses.
module fetch_queue #(
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          reset,
  fetch_queue_if.master bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef logic [CW-1:0] cnt_t;
  typedef logic [AW-1:0] ptr_t;

  logic [31:0] fetch_pc_q, fetch_pc_d;
  cnt_t        occ_q, occ_d;
  cnt_t        inflight_q, inflight_d;
  cnt_t        discard_q, discard_d;
  ptr_t        head_q, head_d;
  ptr_t        tail_q, tail_d;
  ptr_t        pend_rd_q, pend_rd_d;
  ptr_t        pend_wr_q, pend_wr_d;

  logic [31:0] q_pc_q    [DEPTH];
  logic [31:0] q_instr_q [DEPTH];
  logic [31:0] pend_pc_q [DEPTH];

  logic credit_ok;
  logic req_valid;
  logic issue;
  logic resp_ok;
  logic push;
  logic pop;
  logic unused_pc_bits;

  // Credits only count registered occupancy, so a pop frees a slot one cycle later.
  assign credit_ok = ({1'b0, occ_q} + {1'b0, inflight_q}) < (CW+1)'(DEPTH);
  assign req_valid = reset && !bus.redirect && credit_ok;
  assign issue     = req_valid && bus.mem_req_ready;
  assign resp_ok   = bus.mem_resp_valid && (inflight_q != '0);
  assign push      = resp_ok && (discard_q == '0) && !bus.redirect;
  assign pop       = (occ_q != '0) && bus.out_ready;

  assign bus.mem_req_valid = req_valid;
  assign bus.mem_req_addr  = fetch_pc_q;
  assign bus.out_valid     = (occ_q != '0);
  assign bus.out_pc        = q_pc_q[head_q];
  assign bus.out_instr     = q_instr_q[head_q];

  assign unused_pc_bits = ^bus.redirect_pc[1:0];

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    occ_d      = occ_q;
    inflight_d = inflight_q + cnt_t'(issue) - cnt_t'(resp_ok);
    discard_d  = discard_q;
    head_d     = head_q;
    tail_d     = tail_q;
    pend_rd_d  = pend_rd_q + ptr_t'(resp_ok);
    pend_wr_d  = pend_wr_q + ptr_t'(issue);

    if (bus.redirect) begin
      // Everything still in flight, minus a response landing now, is stale.
      fetch_pc_d = {bus.redirect_pc[31:2], 2'b00};
      discard_d  = inflight_q - cnt_t'(resp_ok);
      occ_d      = '0;
      head_d     = '0;
      tail_d     = '0;
    end else begin
      if (issue) begin
        fetch_pc_d = fetch_pc_q + 32'd4;
      end
      if (resp_ok && (discard_q != '0)) begin
        discard_d = discard_q - cnt_t'(1);
      end
      occ_d  = occ_q + cnt_t'(push) - cnt_t'(pop);
      head_d = head_q + ptr_t'(pop);
      tail_d = tail_q + ptr_t'(push);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      fetch_pc_q <= '0;
      occ_q      <= '0;
      inflight_q <= '0;
      discard_q  <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      pend_rd_q  <= '0;
      pend_wr_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        q_pc_q[i]    <= '0;
        q_instr_q[i] <= '0;
        pend_pc_q[i] <= '0;
      end
    end else begin
      fetch_pc_q <= fetch_pc_d;
      occ_q      <= occ_d;
      inflight_q <= inflight_d;
      discard_q  <= discard_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      pend_rd_q  <= pend_rd_d;
      pend_wr_q  <= pend_wr_d;
      if (push) begin
        q_pc_q[tail_q]    <= pend_pc_q[pend_rd_q];
        q_instr_q[tail_q] <= bus.mem_resp_data;
      end
      if (issue) begin
        pend_pc_q[pend_wr_q] <= fetch_pc_q;
      end
    end
  end
endmodule
